qpsk_tx_shaper: RTL and testbench
=================================

Name: qpsk_tx_shaper

Overview:
- Single-branch transmit pulse-shaping block of the QPSK transmitter.
- Consumes one serial bit per symbol period from the PRBS9 source and maps it to a ±1 symbol.
- Upsamples by 4 and filters with a fixed 24-tap raised-cosine FIR (roll-off 0.5, 6-symbol span), implemented polyphase.
- Emits one signed 16-bit sample per clock, toward the DAC/channel model.

Parameters:
- OS, 4, oversampling factor (clock cycles per symbol); fixed at 4, not required to be generic.
- NSYM, 6, filter span in symbols (taps = OS*NSYM = 24).
- COEF_W, 8, coefficient width, signed S(8,7).
- OUT_W, 16, output width.

Ports:
- clk  in  1  sample clock; runs 4x the symbol (bit) rate, rising-edge.
- rst  in  1  asynchronous active-low reset.
- i_tx  in  1  input bit, stable for 4 clk cycles per symbol; 1 maps to +1, 0 maps to -1.
- o_tx  out  16  filtered sample, signed two's complement, LSB weight 2^-7.

Behaviour:
- Reset: while rst=0 (asynchronous), the following are all cleared to 0:
  - phase counter,
  - 6-bit symbol shift register sr,
  - 6-bit valid mask v,
  - o_tx (o_tx=0 immediately on assertion, no clock needed).
- Phase counter:
  - 2-bit, increments every rising clk edge after reset release, wraps 3->0.
- Symbol capture:
  - On the edge where the counter is 3 (counter becomes 0), shift i_tx into sr[0] and shift 1 into v[0]; older entries move up one slot; sr[5]/v[5] are discarded.
  - First capture happens on the 4th rising edge after rst release.
- Symbol value:
  - s_j = +1 if sr[j]=1, -1 if sr[j]=0.
  - s_j = 0 if v[j]=0; empty slots contribute nothing after reset.
- Coefficients h[0..23], symmetric about h[12]:
  - 0,1,2,3,0,-7,-15,-16,0,34,77,114,127,114,77,34,0,-16,-15,-7,0,3,2,1
- Arithmetic:
  - Each edge, o_tx <= sum over j=0..5 of s_j*h[4j+p], where p is the current counter value (before increment).
  - Products are ±coef or 0, so no multipliers are required.
  - Accumulate at ≥11 bits signed and sign-extend to 16 bits; no saturation or rounding is needed (|sum| ≤ 431).
- Latency:
  - o_tx is registered. The first sample using a newly captured symbol (p=0) appears one clk after the capture edge.
  - The symbol centre (h[12]) for symbol n appears at p=0, three symbol periods after its capture.
- ISI-free property: at p=0 only h[12] is non-zero, so the steady-state phase-0 output is exactly ±127.
- Reset mid-operation: o_tx is cleared at once. Counter, sr and v restart; behaviour after release is identical to power-up.
- i_tx is sampled only at the capture edge; changes at other times are ignored.

Test Plan:
- Reset: hold rst=0 with i_tx toggling -> o_tx=0 throughout; assert rst=0 mid-stream -> o_tx=0 asynchronously, before the next clk edge.
- First symbol after release, i_tx=1 -> the four samples after capture are 0,1,2,3. With a second symbol of 1, the next four samples are 0,-6,-13,-13.
- Constant i_tx=1 for ≥6 symbols -> steady repeating pattern 127,129,128,129. Constant i_tx=0 -> -127,-129,-128,-129.
- Alternating 1,0,1,0 for ≥6 symbols -> phase-0 samples alternate +127/-127, with sign matching the bit captured three symbols earlier.
- Drive from the PRBS9 source (seed 9'b010101011) at clk/4 -> every phase-0 sample is ±127, equal to 127*(2*bit-1) of the bit three symbols earlier; no sample exceeds ±431.
- Glitch i_tx between capture edges -> output unchanged versus the clean stream.

Source files
------------

// File: rtl/qpsk_tx_shaper.sv
// QPSK transmit pulse shaper: one bit per 4 clocks mapped to +/-1,
// upsampled x4 and filtered by a 24-tap raised-cosine polyphase FIR.
module qpsk_tx_shaper (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tx,
    output logic [15:0] o_tx
);

    localparam int NSYM = 6;

    logic [1:0]         r_cnt;
    logic [NSYM-1:0]    r_sr;
    logic [NSYM-1:0]    r_v;
    logic [15:0]        r_out;
    logic signed [11:0] w_sum;

    // Raised-cosine taps, symmetric about index 12.
    function automatic logic signed [7:0] f_coef(input logic [4:0] idx);
        logic signed [7:0] c;
        c = 8'sd0;
        case (idx)
            5'd1:    c = 8'sd1;
            5'd2:    c = 8'sd2;
            5'd3:    c = 8'sd3;
            5'd5:    c = -8'sd7;
            5'd6:    c = -8'sd15;
            5'd7:    c = -8'sd16;
            5'd9:    c = 8'sd34;
            5'd10:   c = 8'sd77;
            5'd11:   c = 8'sd114;
            5'd12:   c = 8'sd127;
            5'd13:   c = 8'sd114;
            5'd14:   c = 8'sd77;
            5'd15:   c = 8'sd34;
            5'd17:   c = -8'sd16;
            5'd18:   c = -8'sd15;
            5'd19:   c = -8'sd7;
            5'd21:   c = 8'sd3;
            5'd22:   c = 8'sd2;
            5'd23:   c = 8'sd1;
            default: c = 8'sd0;
        endcase
        return c;
    endfunction

    // Polyphase sum: each valid slot adds or subtracts its phase tap.
    always_comb begin
        w_sum = 12'sd0;
        for (int j = 0; j < NSYM; j++) begin
            logic signed [11:0] w_c;
            w_c = 12'(f_coef(5'(4 * j) + {3'b000, r_cnt}));
            if (r_v[j]) begin
                if (r_sr[j]) w_sum = w_sum + w_c;
                else         w_sum = w_sum - w_c;
            end
        end
    end

    // Phase counter, symbol capture and registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 2'd0;
            r_sr  <= '0;
            r_v   <= '0;
            r_out <= '0;
        end else begin
            r_cnt <= r_cnt + 2'd1;
            r_out <= {{4{w_sum[11]}}, w_sum};
            if (r_cnt == 2'd3) begin
                r_sr <= {r_sr[NSYM-2:0], i_tx};
                r_v  <= {r_v[NSYM-2:0], 1'b1};
            end
        end
    end

    assign o_tx = r_out;

endmodule

// File: tb/tb_qpsk_tx_shaper.sv
// Bench for qpsk_tx_shaper: random, PRBS9, glitch and reset streams
// compared sample-by-sample against a convolution model.
module tb_qpsk_tx_shaper;

    logic        clk;
    logic        rst;
    logic        i_tx;
    logic [15:0] o_tx;

    int ntests;
    int nfail;

    localparam int H[24] = '{0, 1, 2, 3, 0, -7, -15, -16, 0, 34, 77, 114,
                             127, 114, 77, 34, 0, -16, -15, -7, 0, 3, 2, 1};

    int          ph;
    int          hist[$];
    int          got[4];
    logic [8:0]  lfsr;

    qpsk_tx_shaper dut (
        .clk  (clk),
        .rst  (rst),
        .i_tx (i_tx),
        .o_tx (o_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_out();
        int s;
        s = 0;
        for (int j = 0; j < hist.size(); j++)
            s += hist[j] * H[4 * j + ph];
        return s;
    endfunction

    // One clock: drive, step the model, sample 1 time unit after the edge.
    task automatic cyc(input logic b, output int obs);
        int exp;
        int cap;
        i_tx = b;
        @(posedge clk);
        exp = model_out();
        cap = (ph == 3);
        if (cap) begin
            hist.push_front(b ? 1 : -1);
            if (hist.size() > 6) void'(hist.pop_back());
        end
        #1;
        obs = $signed(o_tx);
        chk("sample", obs, exp);
        chk("range", int'(obs <= 431 && obs >= -431), 1);
        if (ph == 0 && hist.size() >= 4)
            chk("centre", obs, 127 * hist[3]);
        ph = (ph + 1) % 4;
    endtask

    // One symbol of four clocks; optional glitching off the capture edge.
    task automatic send(input logic b, input bit glitch);
        logic d;
        for (int k = 0; k < 4; k++) begin
            d = b;
            if (glitch && ph != 3) d = 1'($urandom);
            cyc(d, got[k]);
        end
    endtask

    task automatic prbs_bit(output logic b);
        b = lfsr[8];
        lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_async", $signed(o_tx), 0);
        ph = 0;
        hist.delete();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            i_tx = ~i_tx;
            chk("rst_hold", $signed(o_tx), 0);
        end
        rst = 1'b1;
    endtask

    initial begin
        logic b;
        ntests = 0;
        nfail  = 0;
        ph     = 0;
        i_tx   = 1'b0;
        rst    = 1'b0;
        lfsr   = 9'b010101011;
        #3;
        chk("rst_init", $signed(o_tx), 0);
        @(posedge clk);
        #1;
        do_reset();

        send(1'b1, 1'b0);
        chk("first_p0", got[0], 0);
        send(1'b1, 1'b0);
        chk("sym1_p0", got[0], 0);
        chk("sym1_p1", got[1], 1);
        chk("sym1_p2", got[2], 2);
        chk("sym1_p3", got[3], 3);
        send(1'b1, 1'b0);
        chk("sym2_p0", got[0], 0);
        chk("sym2_p1", got[1], -6);
        chk("sym2_p2", got[2], -13);
        chk("sym2_p3", got[3], -13);
        repeat (5) send(1'b1, 1'b0);
        chk("ones_p0", got[0], 127);
        chk("ones_p1", got[1], 129);
        chk("ones_p2", got[2], 128);
        chk("ones_p3", got[3], 129);
        repeat (7) send(1'b0, 1'b0);
        chk("zeros_p0", got[0], -127);
        chk("zeros_p1", got[1], -129);
        chk("zeros_p2", got[2], -128);
        chk("zeros_p3", got[3], -129);

        for (int k = 0; k < 12; k++) send(1'(k % 2), 1'b0);

        #2;
        do_reset();

        for (int k = 0; k < 80; k++) begin
            prbs_bit(b);
            send(b, 1'b0);
        end

        for (int k = 0; k < 30; k++) send(1'($urandom), 1'b1);

        #2;
        do_reset();

        for (int k = 0; k < 30; k++) send(1'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
